// File: rtl/fft_sdf_stage3_pkg.sv
// Shared types and constants for the stage-3 SDF butterfly.
// Sel encodings match the stage-3 mux sequencer bus.
package fft_sdf_stage3_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MUX_W      = 2;

  typedef enum logic [MUX_W-1:0] {
    SEL_FILL = 2'd0,
    SEL_BFLY = 2'd1,
    SEL_IDLE = 2'd2
  } sel_e;

  function automatic int cplx_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Circular feedback delay line: read-old / write-new at one pointer.
// Frozen (pointer and contents) while en is low.
module sdf_delay_line #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign dout = mem_q[ptr_q];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (en) begin
      mem_d[ptr_q] = din;
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1))
            ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fft_sdf_stage3.sv
// Radix-2 SDF butterfly stage 3 of the 128-point pipelined FFT.
// Fill / butterfly / idle selected by the stage-3 sequencer.
module fft_sdf_stage3
  import fft_sdf_stage3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int SCALE  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MUX_W-1:0]  sel,
  input  logic [DATA_W-1:0] din_re,
  input  logic [DATA_W-1:0] din_im,
  output logic [DATA_W-1:0] dout_re,
  output logic [DATA_W-1:0] dout_im,
  output logic              dout_valid
);

  localparam int CW = cplx_w(DATA_W);

  logic [CW-1:0]     dl_in;
  logic [CW-1:0]     dl_out;
  logic              dl_en;
  logic              is_fill;
  logic              is_bfly;
  logic [DATA_W-1:0] a_re;
  logic [DATA_W-1:0] a_im;

  logic signed [DATA_W:0] sum_re;
  logic signed [DATA_W:0] sum_im;
  logic signed [DATA_W:0] dif_re;
  logic signed [DATA_W:0] dif_im;

  logic [DATA_W-1:0] dout_re_q, dout_re_d;
  logic [DATA_W-1:0] dout_im_q, dout_im_d;
  logic              dout_valid_q, dout_valid_d;
  logic              fb_valid_q, fb_valid_d;

  // Floor shift at full width, then wrap to DATA_W (no saturation).
  function automatic logic [DATA_W-1:0] shr(
    input logic signed [DATA_W:0] x
  );
    logic signed [DATA_W:0] y;
    y = x >>> SCALE;
    return y[DATA_W-1:0];
  endfunction

  assign is_fill = (sel == SEL_FILL);
  assign is_bfly = (sel == SEL_BFLY);
  assign dl_en   = is_fill | is_bfly;
  assign a_re    = dl_out[CW-1:DATA_W];
  assign a_im    = dl_out[DATA_W-1:0];

  always_comb begin
    sum_re = {a_re[DATA_W-1], a_re} + {din_re[DATA_W-1], din_re};
    sum_im = {a_im[DATA_W-1], a_im} + {din_im[DATA_W-1], din_im};
    dif_re = {a_re[DATA_W-1], a_re} - {din_re[DATA_W-1], din_re};
    dif_im = {a_im[DATA_W-1], a_im} - {din_im[DATA_W-1], din_im};
  end

  always_comb begin
    dl_in        = {din_re, din_im};
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_valid_d = 1'b0;
    fb_valid_d   = fb_valid_q;
    unique case (1'b1)
      is_fill: begin
        dout_re_d    = a_re;
        dout_im_d    = a_im;
        dout_valid_d = fb_valid_q;
      end
      is_bfly: begin
        dl_in        = {shr(dif_re), shr(dif_im)};
        dout_re_d    = shr(sum_re);
        dout_im_d    = shr(sum_im);
        dout_valid_d = 1'b1;
        fb_valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  sdf_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (dl_en),
    .din     (dl_in),
    .dout    (dl_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_valid_q <= 1'b0;
      fb_valid_q   <= 1'b0;
    end else begin
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_valid_q <= dout_valid_d;
      fb_valid_q   <= fb_valid_d;
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_valid = dout_valid_q;

endmodule
